// File: rtl/itl_dibit_byte_packer_if.sv
`default_nettype none
// =============================================================================
// Module      : itl_dibit_byte_packer_if
// Description : Byte stream from the dibit packer FIFO head to its consumer.
// Revision    : 1.0 - initial release
// =============================================================================
interface itl_dibit_byte_packer_if;
    logic [7:0] byte_out;
    logic       byte_vld;
    logic       byte_rdy;
    logic       byte_sop;
    logic       byte_eop;

    modport master (
        output byte_out,
        output byte_vld,
        output byte_sop,
        output byte_eop,
        input  byte_rdy
    );

    modport slave (
        input  byte_out,
        input  byte_vld,
        input  byte_sop,
        input  byte_eop,
        output byte_rdy
    );
endinterface
`default_nettype wire

// File: rtl/itl_dibit_byte_packer.sv
`default_nettype none
// =============================================================================
// Module      : itl_dibit_byte_packer
// Description : Packs the interleaver dibit stream into PB-framed bytes behind
//               a small show-ahead FIFO. Define ITL_PACK_LSB_FIRST_EN to place
//               the first dibit of each byte in [1:0] instead of [7:6].
// Revision    : 1.0 - initial release
// =============================================================================
module itl_dibit_byte_packer #(
    parameter int FIFO_AW = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     pb_size,
    input  logic                           blk_start,
    input  logic [1:0]                     din,
    input  logic                           din_vld,
    itl_dibit_byte_packer_if.master        bo,
    output logic                           busy,
    output logic                           ovf_err,
    output logic                           len_err,
    input  logic                           err_clr
);

    localparam int c_DEPTH = 2 ** FIFO_AW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PACK  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t           r_state;
    logic [11:0]      r_dibit_cnt;
    logic [11:0]      r_last_idx;
    logic [7:0]       r_asm;
    logic             r_push_vld;
    logic [9:0]       r_push_data;
    logic [FIFO_AW:0] r_wr_ptr;
    logic [FIFO_AW:0] r_rd_ptr;
    logic [9:0]       r_mem [c_DEPTH];
    logic             r_ovf;
    logic             r_len;

    logic [7:0]       w_asm_next;
    logic             w_pack_dibit;
    logic             w_byte_done;
    logic             w_last;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_wr;
    logic             w_ovf_evt;
    logic             w_len_evt;
    logic [9:0]       w_head;

`ifdef ITL_PACK_LSB_FIRST_EN
    assign w_asm_next = {din, r_asm[7:2]};
`else
    assign w_asm_next = {r_asm[5:0], din};
`endif

    assign w_pack_dibit = (r_state == ST_PACK) && din_vld;
    assign w_byte_done  = w_pack_dibit && (r_dibit_cnt[1:0] == 2'b11);
    assign w_last       = w_pack_dibit && (r_dibit_cnt == r_last_idx);

    // Extra pointer MSB separates full (MSBs differ) from empty (equal).
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                       (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign w_pop     = !w_empty && bo.byte_rdy;
    assign w_wr      = r_push_vld && (!w_full || w_pop);
    assign w_ovf_evt = r_push_vld && w_full && !w_pop;
    assign w_len_evt = (blk_start && ((r_state != ST_IDLE) || (pb_size == 2'd3))) ||
                       (din_vld && (r_state != ST_PACK));

    assign w_head      = r_mem[r_rd_ptr[FIFO_AW-1:0]];
    assign bo.byte_vld = !w_empty;
    assign bo.byte_out = w_empty ? 8'h00 : w_head[7:0];
    assign bo.byte_sop = !w_empty && w_head[8];
    assign bo.byte_eop = !w_empty && w_head[9];

    assign busy    = (r_state != ST_IDLE);
    assign ovf_err = r_ovf;
    assign len_err = r_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_dibit_cnt <= 12'd0;
            r_last_idx  <= 12'd0;
            r_asm       <= 8'h00;
            r_push_vld  <= 1'b0;
            r_push_data <= 10'd0;
        end else begin
            r_push_vld <= w_byte_done;
            if (w_byte_done) begin
                r_push_data <= {w_last, (r_dibit_cnt[11:2] == 10'd0), w_asm_next};
            end
            case (r_state)
                ST_IDLE: begin
                    if (blk_start && (pb_size != 2'd3)) begin
                        case (pb_size)
                            2'd0:    r_last_idx <= 12'd63;
                            2'd1:    r_last_idx <= 12'd543;
                            default: r_last_idx <= 12'd2079;
                        endcase
                        r_dibit_cnt <= 12'd0;
                        r_asm       <= 8'h00;
                        r_state     <= ST_PACK;
                    end
                end
                ST_PACK: begin
                    if (din_vld) begin
                        r_asm       <= w_asm_next;
                        r_dibit_cnt <= r_dibit_cnt + 12'd1;
                        if (w_last) begin
                            r_state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    // The final byte may still be in the push stage, not yet in the FIFO.
                    if (w_empty && !r_push_vld) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= r_push_data;
        end
    end

    // A new error event in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_len <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (err_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_len_evt) begin
                r_len <= 1'b1;
            end else if (err_clr) begin
                r_len <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/itl_dibit_byte_packer.md
Name: itl_dibit_byte_packer

Overview:
- Sits directly downstream of the turbo interleaver/deinterleaver top and consumes its serial dibit output stream (rdata0/dout_vld).
- Packs 4 dibits into one byte and frames each physical block (PB) with start/end markers, using the PB length from pb_size.
- Buffers bytes in a small FIFO so the downstream consumer may apply backpressure; the interleaver itself cannot be stalled.
- Flags overflow and length violations with sticky error bits.

Parameters:
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW entries of 10 bits (byte + sop + eop).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- pb_size  in  2  PB size code: 0=16 B (64 dibits), 1=136 B (544), 2=520 B (2080), 3=reserved; sampled on blk_start
- blk_start  in  1  one-cycle pulse marking a new block (same pulse that starts the interleaver read-out)
- din  in  2  dibit from interleaver (rdata0)
- din_vld  in  1  din valid (dout_vld)
- byte_out  out  8  packed byte at FIFO head
- byte_vld  out  1  FIFO non-empty
- byte_rdy  in  1  consumer ready; pop when byte_vld & byte_rdy
- byte_sop  out  1  head byte is first of PB
- byte_eop  out  1  head byte is last of PB
- busy  out  1  state != IDLE
- ovf_err  out  1  sticky: byte lost to full FIFO
- len_err  out  1  sticky: framing violation
- err_clr  in  1  clears ovf_err/len_err

Behaviour:
- Reset (async, rst=1): state IDLE, all counters 0, FIFO empty. byte_out=8'h00, byte_vld=0, byte_sop=0, byte_eop=0, busy=0, ovf_err=0, len_err=0. Asserting rst mid-block discards all partial and buffered data.
- States:
  - IDLE: on blk_start with pb_size in {0,1,2}, latch the expected dibit count (64/544/2080), clear dibit_cnt (12 bit) and the shift register, go to PACK. blk_start with pb_size=3 sets len_err and stays in IDLE. din_vld in IDLE sets len_err; din is discarded.
  - PACK: each din_vld shifts din into the 8-bit assembly register, first dibit into [7:6] (MSB first), and increments dibit_cnt. On the 4th dibit of a byte (dibit_cnt[1:0]==3), push {eop, sop, byte} into the FIFO on the next clock edge. sop=1 when byte index==0; eop=1 when dibit_cnt==expected-1. After the eop push, go to FLUSH.
  - FLUSH: wait until the FIFO is empty, then go to IDLE. din_vld in FLUSH sets len_err and is discarded.
- blk_start in PACK or FLUSH: sets len_err and is ignored; the current block continues.
- Latency: 4th dibit sampled at edge N -> byte written at edge N+1 -> byte_vld high after edge N+1 (registered FIFO head, show-ahead).
- FIFO:
  - Full + push without pop: byte dropped, ovf_err set, counters still advance so framing stays aligned.
  - Full + push + pop in the same cycle: legal, no overflow.
  - Empty + pop: impossible, because byte_vld=0.
  - Pointers wrap modulo depth; one extra bit distinguishes full from empty.
- Sticky errors: err_clr clears them. If err_clr and a new error event occur in the same cycle, the error wins.
- busy=1 in PACK and FLUSH.

Optional Feature:
- Macro: ITL_PACK_LSB_FIRST_EN.
- Defined: the first dibit of each byte goes to [1:0], the second to [3:2], the third to [5:4], the fourth to [7:6].
- Undefined: MSB-first packing as above.
- Framing, latency and error behaviour are identical in both builds.

Test Plan:
- pb_size=0, blk_start, 64 dibits 2'b00,01,10,11 repeating, byte_rdy=1 -> 16 bytes of 8'h1B. byte_sop on byte 0 only, byte_eop on byte 15 only. busy falls after the last pop. No errors.
- pb_size=2, 2080 random dibits back-to-back, byte_rdy=1 -> 520 bytes matching the reference packing. eop on byte 519. Repeat with a pb_size=1 block afterwards -> 136 bytes.
- pb_size=1, byte_rdy=0 throughout -> FIFO holds 8 bytes, byte 9 and later are dropped and ovf_err=1. Raise byte_rdy -> 8 bytes drain, busy=0. err_clr -> ovf_err=0.
- blk_start with pb_size=3 -> len_err=1, busy stays 0. din_vld pulse in IDLE -> len_err=1, no byte produced.
- blk_start again during PACK at dibit 30 of a pb_size=0 block -> len_err=1, and the block still completes with 16 bytes.
- Assert rst after 20 dibits -> all outputs 0 immediately (asynchronously). A new pb_size=0 block afterwards produces 16 correct bytes.
